// File: rtl/dds_pio_pkg.sv
// Shared definitions for the DDS control-strobe PIO: register offsets and
// the pulse timer state encoding.
package dds_pio_pkg;

    localparam logic [2:0] REG_DATA      = 3'd0;
    localparam logic [2:0] REG_SET       = 3'd1;
    localparam logic [2:0] REG_CLEAR     = 3'd2;
    localparam logic [2:0] REG_PULSE     = 3'd3;
    localparam logic [2:0] REG_PULSE_LEN = 3'd4;
    localparam logic [2:0] REG_BUSY      = 3'd5;

    typedef enum logic {
        IDLE,
        PULSING
    } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: tracks which out_port bits belong to the running
// pulse and flags the edge on which they must be dropped.
module pio_pulse_timer
    import dds_pio_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] add_mask,
    input  logic [WIDTH-1:0] remove_mask,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] mask,
    output logic             expire,
    output logic             active
);

    pulse_state_t     state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    // A new pulse always wins over expiry, so stacked pulses never glitch low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q & ~remove_mask;
        expire  = 1'b0;
        if (load) begin
            mask_d  = (mask_q & ~remove_mask) | add_mask;
            cnt_d   = (len == '0) ? '0 : len - LEN_W'(1);
            state_d = PULSING;
        end else if (state_q == PULSING) begin
            if (cnt_q == '0) begin
                expire  = 1'b1;
                mask_d  = '0;
                state_d = IDLE;
            end else if (mask_d == '0) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q - LEN_W'(1);
            end
        end
    end

    assign mask   = mask_q;
    assign active = (state_q == PULSING);

endmodule

// File: rtl/dds_pulse_pio.sv
// Avalon-MM output port for the DDS strobes with set/clear registers and a
// hardware one-shot pulse of programmable length.
module dds_pulse_pio
    import dds_pio_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               LEN_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_active
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] out_q, out_d;
    logic [LEN_W-1:0] len_q;
    logic             load;
    logic [WIDTH-1:0] add_mask, remove_mask;
    logic [WIDTH-1:0] mask;
    logic             expire;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = &{1'b0, writedata};

    pio_pulse_timer #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .add_mask   (add_mask),
        .remove_mask(remove_mask),
        .len        (len_q),
        .mask       (mask),
        .expire     (expire),
        .active     (pulse_active)
    );

    // Written bits leave the pulse mask, so expiry only drops bits still owned by the pulse.
    always_comb begin
        out_d       = out_q;
        load        = 1'b0;
        add_mask    = '0;
        remove_mask = '0;
        if (wr) begin
            case (address)
                REG_DATA: begin
                    out_d       = wd;
                    remove_mask = '1;
                end
                REG_SET: begin
                    out_d       = out_q | wd;
                    remove_mask = wd;
                end
                REG_CLEAR: begin
                    out_d       = out_q & ~wd;
                    remove_mask = wd;
                end
                REG_PULSE: begin
                    out_d    = out_q | wd;
                    add_mask = wd;
                    load     = |wd;
                end
                default: ;
            endcase
        end
        if (expire) begin
            out_d = out_d & ~(mask & ~remove_mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RESET_VALUE;
            len_q <= LEN_W'(1);
        end else begin
            out_q <= out_d;
            if (wr && address == REG_PULSE_LEN) begin
                len_q <= writedata[LEN_W-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:      readdata = 32'(out_q);
            REG_PULSE_LEN: readdata = 32'(len_q);
            REG_BUSY:      readdata = 32'(mask);
            default:       readdata = '0;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_dds_pulse_pio.sv
// Scoreboard bench for dds_pulse_pio: a cycle-indexed reference model predicts
// out_port and pulse_active after every edge and the register read-back values.
module tb_dds_pulse_pio;

    localparam logic [1:0] RST_VAL = 2'b10;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic        pulse_active;

    dds_pulse_pio #(
        .WIDTH(2),
        .RESET_VALUE(RST_VAL),
        .LEN_W(16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .out_port    (out_port),
        .pulse_active(pulse_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] out;
        logic       act;
        int         cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [1:0]  m_out;
    logic [1:0]  m_mask;
    logic [15:0] m_len;
    int          m_end;
    int          m_cycle;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_out  = RST_VAL;
        m_mask = 2'b00;
        m_len  = 16'd1;
        m_end  = -1;
        sb_q.delete();
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] addr);
        case (addr)
            3'd0:    return {30'd0, m_out};
            3'd4:    return {16'd0, m_len};
            3'd5:    return {30'd0, m_mask};
            default: return 32'd0;
        endcase
    endfunction

    // Drive one bus cycle, predict the state after the edge, then compare.
    task automatic applyStimulus(input logic wr, input logic [2:0] addr, input logic [31:0] data);
        logic [1:0] wdv, nout, nmask, rem;
        logic       pulse_hit;
        exp_t       e, got;
        chipselect = 1'b1;
        write_n    = !wr;
        address    = addr;
        writedata  = data;
        m_cycle++;
        wdv       = data[1:0];
        nout      = m_out;
        nmask     = m_mask;
        rem       = 2'b00;
        pulse_hit = 1'b0;
        if (wr) begin
            case (addr)
                3'd0: begin nout = wdv;         rem = 2'b11; end
                3'd1: begin nout = m_out | wdv;  rem = wdv;   end
                3'd2: begin nout = m_out & ~wdv; rem = wdv;   end
                3'd3: if (wdv != 2'b00) begin
                    nout      = m_out | wdv;
                    nmask     = m_mask | wdv;
                    m_end     = m_cycle + ((m_len == 16'd0) ? 1 : int'(m_len));
                    pulse_hit = 1'b1;
                end
                default: ;
            endcase
        end
        if (!pulse_hit) begin
            nmask = m_mask & ~rem;
            if (m_mask != 2'b00 && m_cycle == m_end) begin
                nout  = nout & ~nmask;
                nmask = 2'b00;
            end
        end
        if (wr && addr == 3'd4) m_len = data[15:0];
        m_out  = nout;
        m_mask = nmask;
        e.out = nout;
        e.act = (nmask != 2'b00);
        e.cyc = m_cycle;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checkOutput($sformatf("out_port@%0d", got.cyc), {30'd0, out_port}, {30'd0, got.out});
        checkOutput($sformatf("pulse_active@%0d", got.cyc), {31'd0, pulse_active}, {31'd0, got.act});
    endtask

    task automatic readCheck(input logic [2:0] addr, input string tag);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = addr;
        #1;
        checkOutput(tag, readdata, modelRead(addr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 32'd0);
    endtask

    initial begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        m_cycle    = 0;
        reset_n    = 1'b1;
        modelReset();
        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_out_port", {30'd0, out_port}, 32'd2);
        checkOutput("reset_active", {31'd0, pulse_active}, 32'd0);
        readCheck(3'd0, "reset_rd_data");
        checkOutput("reset_rd_data_const", readdata, 32'd2);
        readCheck(3'd4, "reset_rd_len");
        checkOutput("reset_rd_len_const", readdata, 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        applyStimulus(1'b1, 3'd0, 32'd3);
        applyStimulus(1'b1, 3'd2, 32'd1);
        applyStimulus(1'b1, 3'd1, 32'd0);
        checkOutput("data_after_set0", {30'd0, out_port}, 32'd2);
        readCheck(3'd0, "rd_data");
        readCheck(3'd1, "rd_set");
        readCheck(3'd2, "rd_clear");

        applyStimulus(1'b1, 3'd0, 32'd0);
        applyStimulus(1'b1, 3'd4, 32'd5);
        applyStimulus(1'b1, 3'd3, 32'd1);
        readCheck(3'd5, "busy_during_pulse");
        checkOutput("busy_during_const", readdata, 32'd1);
        idle(6);
        readCheck(3'd5, "busy_after_pulse");

        applyStimulus(1'b1, 3'd4, 32'd0);
        readCheck(3'd4, "rd_len_zero");
        applyStimulus(1'b1, 3'd3, 32'd3);
        idle(3);

        applyStimulus(1'b1, 3'd4, 32'd10);
        applyStimulus(1'b1, 3'd3, 32'd1);
        idle(3);
        applyStimulus(1'b1, 3'd3, 32'd2);
        idle(12);
        applyStimulus(1'b1, 3'd3, 32'd1);
        idle(9);
        applyStimulus(1'b1, 3'd3, 32'd2);
        idle(12);

        applyStimulus(1'b1, 3'd4, 32'd8);
        applyStimulus(1'b1, 3'd3, 32'd3);
        idle(2);
        applyStimulus(1'b1, 3'd1, 32'd1);
        idle(8);
        checkOutput("set_override_final", {30'd0, out_port}, 32'd1);

        applyStimulus(1'b1, 3'd0, 32'd0);
        applyStimulus(1'b1, 3'd3, 32'd3);
        idle(2);
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_out_port", {30'd0, out_port}, 32'd2);
        checkOutput("midreset_active", {31'd0, pulse_active}, 32'd0);
        readCheck(3'd4, "midreset_rd_len");
        #1 reset_n = 1'b1;
        idle(2);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd4) ? 32'($urandom_range(0, 6)) : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, a, d);
            readCheck(3'($urandom_range(0, 7)), $sformatf("rand_rd_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
